// File: rtl/convertidor_bin_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Saturates to all nines when the operand does not fit in N_DIG digits.
module convertidor_bin_bcd_secuencial #(
    parameter int W_BIN = 8,
    parameter int N_DIG = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [W_BIN-1:0]   dato,
    output logic               busy,
    output logic               done,
    output logic [4*N_DIG-1:0] bcd,
    output logic               ovf
);

    localparam int SW = 4 * (N_DIG + 1);
    localparam int CW = $clog2(W_BIN + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(N_DIG);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_n;
    logic [W_BIN-1:0]   bin_q, bin_n;
    logic [SW-1:0]      scr_q, scr_n, adj;
    logic [CW-1:0]      cnt_q, cnt_n;
    logic               flag_q, flag_n;
    logic [4*N_DIG-1:0] bcd_n;
    logic               ovf_n, done_n;

    // Extra guard digit keeps the add-3 step from wrapping on overflowing operands
    always_comb begin
        adj = scr_q;
        for (int d = 0; d < N_DIG + 1; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_n = state;
        bin_n   = bin_q;
        scr_n   = scr_q;
        cnt_n   = cnt_q;
        flag_n  = flag_q;
        bcd_n   = bcd;
        ovf_n   = ovf;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    bin_n   = dato;
                    scr_n   = '0;
                    cnt_n   = CW'(W_BIN);
                    flag_n  = 64'(dato) >= LIMIT;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                {scr_n, bin_n} = {adj, bin_q} << 1;
                cnt_n = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    ovf_n   = flag_q;
                    bcd_n   = flag_q ? {N_DIG{4'h9}} : scr_n[4*N_DIG-1:0];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            bin_q  <= '0;
            scr_q  <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            bin_q  <= bin_n;
            scr_q  <= scr_n;
            cnt_q  <= cnt_n;
            flag_q <= flag_n;
            bcd    <= bcd_n;
            ovf    <= ovf_n;
            done   <= done_n;
        end
    end

    assign busy = (state == SHIFT);

endmodule
